// File: rtl/pixel_frame_writer_pkg.sv
// pixel_frame_writer shared types: pixel layout and capture FSM states.
// Optional feature macro: PIXEL_FRAME_WRITER_CHECKSUM_EN (see top).
package pixel_frame_writer_pkg;

  localparam int PIX_W = 24;
  localparam int R_LSB = 16;
  localparam int G_LSB = 8;
  localparam int B_LSB = 0;
  localparam int CH_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  function automatic logic [15:0] rgb_sum(input logic [PIX_W-1:0] p);
    return 16'(p[R_LSB +: CH_W]) + 16'(p[G_LSB +: CH_W]) +
           16'(p[B_LSB +: CH_W]);
  endfunction

endpackage

// File: rtl/pixel_frame_writer_sync_fifo.sv
// pixel_sync_fifo: registered synchronous FIFO with full/empty flags.
// DEPTH must be a power of two; push when full and pop when empty are ignored.
module pixel_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wp_q, wp_d;
  logic [PW-1:0]    rp_q, rp_d;
  logic [PW:0]      cnt_q, cnt_d;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt_q == (PW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign rdata   = mem_q[rp_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // next storage, pointers and occupancy
  always_comb begin
    mem_d = mem_q;
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (do_push) begin
      mem_d[wp_q] = wdata;
      wp_d        = wp_q + 1'b1;
    end
    if (do_pop) begin
      rp_d = rp_q + 1'b1;
    end
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // state registers; storage cleared so the head reads 0 after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pixel_frame_writer.sv
// pixel_frame_writer: captures one raster frame into a RAM write port.
// Define PIXEL_FRAME_WRITER_CHECKSUM_EN to add the frame_checksum output.
module pixel_frame_writer
  import pixel_frame_writer_pkg::*;
#(
  parameter int IMG_W      = 512,
  parameter int IMG_H      = 512,
  parameter int ADDR_W     = 18,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [PIX_W-1:0]  pixel_in,
  input  logic              data_valid_in,
  output logic              in_ready,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [PIX_W-1:0]  mem_wr_data,
  input  logic              mem_wr_ready,
  output logic              busy,
  output logic              frame_done,
  output logic              overflow
`ifdef PIXEL_FRAME_WRITER_CHECKSUM_EN
  ,
  output logic [15:0]       frame_checksum
`endif
);

  localparam int TOTAL = IMG_W * IMG_H;

  state_e            state_q, state_d;
  logic [ADDR_W:0]   acc_q, acc_d;
  logic [ADDR_W-1:0] wr_q, wr_d;
  logic              ovf_q, ovf_d;
  logic              fifo_full;
  logic              fifo_empty;
  logic [PIX_W-1:0]  fifo_head;
  logic              accept;
  logic              wr_hs;
  logic              last_wr;

  pixel_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PIX_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .wdata (pixel_in),
    .pop   (wr_hs),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign in_ready    = (state_q == ST_CAPTURE) && !fifo_full &&
                       (acc_q < (ADDR_W+1)'(TOTAL));
  assign accept      = data_valid_in && in_ready;
  assign mem_wr_en   = !fifo_empty;
  assign mem_wr_data = fifo_head;
  assign mem_wr_addr = wr_q;
  assign wr_hs       = mem_wr_en && mem_wr_ready;
  assign last_wr     = (wr_q == ADDR_W'(TOTAL - 1));
  assign busy        = (state_q == ST_CAPTURE);
  assign frame_done  = (state_q == ST_DONE);
  assign overflow    = ovf_q;

  // capture FSM, input/write counters and sticky overflow
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    wr_d    = wr_q;
    ovf_d   = ovf_q;
    if (accept) acc_d = acc_q + 1'b1;
    if (wr_hs)  wr_d  = wr_q + 1'b1;
    if (data_valid_in && !in_ready) ovf_d = 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_CAPTURE;
          acc_d   = '0;
          wr_d    = '0;
          ovf_d   = 1'b0;
        end
      end
      ST_CAPTURE: begin
        if (wr_hs && last_wr) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // control state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      wr_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      wr_q    <= wr_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef PIXEL_FRAME_WRITER_CHECKSUM_EN
  logic [15:0] cks_q, cks_d;

  assign frame_checksum = cks_q;

  // running R+G+B sum of written pixels, cleared when a frame is armed
  always_comb begin
    cks_d = cks_q;
    if (state_q == ST_IDLE && start) begin
      cks_d = '0;
    end else if (wr_hs) begin
      cks_d = cks_q + rgb_sum(fifo_head);
    end
  end

  // checksum register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cks_q <= '0;
    else     cks_q <= cks_d;
  end
`endif

endmodule

// File: tb/tb_pixel_frame_writer.sv
// tb_pixel_frame_writer: directed table, corner sequences and random frames
// checked against a queue-based frame model (IMG_W=4, IMG_H=2).
module tb_pixel_frame_writer;

  localparam int W   = 4;
  localparam int H   = 2;
  localparam int AW  = 3;
  localparam int DEP = 4;
  localparam int N   = W * H;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [23:0]   pixel_in;
  logic          data_valid_in;
  logic          in_ready;
  logic          mem_wr_en;
  logic [AW-1:0] mem_wr_addr;
  logic [23:0]   mem_wr_data;
  logic          mem_wr_ready;
  logic          busy;
  logic          frame_done;
  logic          overflow;
`ifdef PIXEL_FRAME_WRITER_CHECKSUM_EN
  logic [15:0]   frame_checksum;
`endif

  pixel_frame_writer #(
    .IMG_W      (W),
    .IMG_H      (H),
    .ADDR_W     (AW),
    .FIFO_DEPTH (DEP)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .pixel_in      (pixel_in),
    .data_valid_in (data_valid_in),
    .in_ready      (in_ready),
    .mem_wr_en     (mem_wr_en),
    .mem_wr_addr   (mem_wr_addr),
    .mem_wr_data   (mem_wr_data),
    .mem_wr_ready  (mem_wr_ready),
    .busy          (busy),
    .frame_done    (frame_done),
    .overflow      (overflow)
`ifdef PIXEL_FRAME_WRITER_CHECKSUM_EN
    ,
    .frame_checksum (frame_checksum)
`endif
  );

  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // frame model: armed flag, done pulse, counts and a pixel queue
  bit          m_busy, m_done, m_ovf;
  int          m_acc, m_wr;
  logic [23:0] m_q[$];
  logic [15:0] m_cks;
  bit          e_rdy, e_en, e_idle;
  int          dut_wr, rdy_hi;

  function automatic void m_reset();
    m_busy = 0; m_done = 0; m_ovf = 0;
    m_acc = 0; m_wr = 0; m_cks = '0;
    m_q.delete();
  endfunction

  function automatic logic [15:0] sum3(input logic [23:0] p);
    return 16'(p[23:16]) + 16'(p[15:8]) + 16'(p[7:0]);
  endfunction

  task automatic model_check();
    e_rdy  = m_busy && (m_q.size() < DEP) && (m_acc < N);
    e_en   = (m_q.size() > 0);
    e_idle = !m_busy && !m_done;
    chk("in_ready", 32'(in_ready), 32'(e_rdy));
    chk("mem_wr_en", 32'(mem_wr_en), 32'(e_en));
    if (e_en) begin
      chk("mem_wr_addr", 32'(mem_wr_addr), 32'(m_wr));
      chk("mem_wr_data", 32'(mem_wr_data), 32'(m_q[0]));
    end
    chk("busy", 32'(busy), 32'(m_busy));
    chk("frame_done", 32'(frame_done), 32'(m_done));
    chk("overflow", 32'(overflow), 32'(m_ovf));
`ifdef PIXEL_FRAME_WRITER_CHECKSUM_EN
    if (m_done) chk("frame_checksum", 32'(frame_checksum), 32'(m_cks));
`endif
  endtask

  function automatic void model_update();
    bit hs;
    bit acc;
    hs  = e_en && mem_wr_ready;
    acc = data_valid_in && e_rdy;
    m_done = 0;
    if (hs) begin
      m_cks = m_cks + sum3(m_q[0]);
      void'(m_q.pop_front());
      m_wr++;
      if (m_wr == N) begin
        m_busy = 0;
        m_done = 1;
      end
    end
    if (acc) begin
      m_q.push_back(pixel_in);
      m_acc++;
    end
    if (data_valid_in && !e_rdy) m_ovf = 1;
    if (start && e_idle) begin
      m_busy = 1; m_acc = 0; m_wr = 0; m_ovf = 0; m_cks = '0;
    end
  endfunction

  task automatic tick();
    @(negedge clk);
    model_check();
    if (mem_wr_en && mem_wr_ready) dut_wr++;
    if (in_ready) rdy_hi++;
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drive(input bit s, input bit v, input logic [23:0] p,
                       input bit r);
    start = s; data_valid_in = v; pixel_in = p; mem_wr_ready = r;
    tick();
  endtask

  task automatic wait_done(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      if (m_done) break;
      drive(1'b0, 1'b0, 24'h0, 1'b1);
    end
    if (!m_done) begin
      chk("frame_timeout", 32'(i), 32'(budget + 1));
    end else begin
      drive(1'b0, 1'b0, 24'h0, 1'b1);
    end
  endtask

  typedef struct {
    bit          s;
    bit          v;
    logic [23:0] p;
    bit          r;
    bit          e_rdy;
    bit          e_en;
    logic [2:0]  e_addr;
    logic [23:0] e_data;
    bit          e_busy;
    bit          e_done;
  } vec_t;

  vec_t tv[12];

  initial begin
    tv[0] = '{1'b1, 1'b0, 24'h0, 1'b1, 1'b0, 1'b0, 3'd0, 24'h0, 1'b0, 1'b0};
    for (int k = 1; k <= 8; k++) begin
      tv[k] = '{1'b0, 1'b1, 24'(k), 1'b1, 1'b1, (k >= 2),
                (k >= 2) ? 3'(k - 2) : 3'd0, 24'(k - 1), 1'b1, 1'b0};
    end
    tv[9]  = '{1'b0, 1'b0, 24'h0, 1'b1, 1'b0, 1'b1, 3'd7, 24'd8, 1'b1, 1'b0};
    tv[10] = '{1'b0, 1'b0, 24'h0, 1'b1, 1'b0, 1'b0, 3'd0, 24'h0, 1'b0, 1'b1};
    tv[11] = '{1'b0, 1'b0, 24'h0, 1'b1, 1'b0, 1'b0, 3'd0, 24'h0, 1'b0, 1'b0};

    rst = 1'b1; start = 1'b0; pixel_in = '0;
    data_valid_in = 1'b0; mem_wr_ready = 1'b0;
    m_reset();
    #2;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_wr_en", 32'(mem_wr_en), 32'd0);
    chk("rst_wr_addr", 32'(mem_wr_addr), 32'd0);
    chk("rst_wr_data", 32'(mem_wr_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
`ifdef PIXEL_FRAME_WRITER_CHECKSUM_EN
    chk("rst_cks", 32'(frame_checksum), 32'd0);
`endif
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // directed frame from the table
    for (int i = 0; i < 12; i++) begin
      start = tv[i].s; data_valid_in = tv[i].v;
      pixel_in = tv[i].p; mem_wr_ready = tv[i].r;
      #1;
      chk("tv_in_ready", 32'(in_ready), 32'(tv[i].e_rdy));
      chk("tv_wr_en", 32'(mem_wr_en), 32'(tv[i].e_en));
      if (tv[i].e_en) begin
        chk("tv_addr", 32'(mem_wr_addr), 32'(tv[i].e_addr));
        chk("tv_data", 32'(mem_wr_data), 32'(tv[i].e_data));
      end
      chk("tv_busy", 32'(busy), 32'(tv[i].e_busy));
      chk("tv_done", 32'(frame_done), 32'(tv[i].e_done));
      chk("tv_ovf", 32'(overflow), 32'd0);
      tick();
    end

    // valid pixel while idle: overflow, no write; start clears it
    drive(1'b0, 1'b1, 24'hABCDEF, 1'b1);
    chk("idle_ovf", 32'(overflow), 32'd1);
    chk("idle_no_wr", 32'(mem_wr_en), 32'd0);
    drive(1'b1, 1'b0, 24'h0, 1'b0);
    chk("start_clr_ovf", 32'(overflow), 32'd0);

    // RAM stall: only FIFO_DEPTH accepts, then drain in order
    rdy_hi = 0;
    repeat (6) drive(1'b0, 1'b1, 24'(m_acc + 1), 1'b0);
    chk("stall_accepts", 32'(rdy_hi), 32'd4);
    for (int i = 0; i < 40 && m_acc < N; i++) begin
      drive(1'b0, 1'b1, 24'(m_acc + 1), 1'b1);
    end
    wait_done(40);

    // ninth pixel rejected, eight writes
    dut_wr = 0;
    drive(1'b1, 1'b0, 24'h0, 1'b1);
    for (int i = 0; i < 9; i++) drive(1'b0, 1'b1, 24'h100 + 24'(i), 1'b1);
    chk("ninth_ovf", 32'(overflow), 32'd1);
    wait_done(40);
    chk("ninth_writes", 32'(dut_wr), 32'd8);

    // async reset mid-frame
    drive(1'b1, 1'b0, 24'h0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 24'h200 + 24'(i), 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_wr_en", 32'(mem_wr_en), 32'd0);
    chk("mid_rst_addr", 32'(mem_wr_addr), 32'd0);
    chk("mid_rst_data", 32'(mem_wr_data), 32'd0);
    chk("mid_rst_done", 32'(frame_done), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd0);
    m_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    drive(1'b1, 1'b0, 24'h0, 1'b1);
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, 24'h010203, 1'b1);
    wait_done(40);
`ifdef PIXEL_FRAME_WRITER_CHECKSUM_EN
    chk("cks_010203", 32'(frame_checksum), 32'h0030);
`endif

    // random frames with random stalls and stray starts
    for (int f = 0; f < 8; f++) begin
      drive(1'b1, 1'b0, 24'h0, 1'($urandom_range(0, 1)));
      for (int c = 0; c < 400 && !m_done; c++) begin
        drive(($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 7),
              24'($urandom), ($urandom_range(0, 9) < 6));
      end
      wait_done(40);
      repeat ($urandom_range(0, 3)) drive(1'b0, 1'b0, 24'h0, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
